// File: rtl/ccr_controller.sv
// Condition Code Register controller: per-opcode flag latching, branch resolution, SETC/CLRC,
// and interrupt save/restore through a shadow register. Define CCR_FWD_EN to forward ALU flags into branches.
module ccr_controller #(
    parameter int FLUSH_CYCLES = 2,
    parameter int STATUS_W     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    input  logic                stall,
    input  logic [3:0]          alu_op,
    input  logic [STATUS_W-1:0] alu_status,
    input  logic                setc,
    input  logic                clrc,
    input  logic                br_valid,
    input  logic [1:0]          br_cond,
    output logic                br_taken,
    input  logic                int_save,
    input  logic                rti_restore,
    output logic [STATUS_W-1:0] ccr,
    output logic                shadow_valid,
    output logic                seq_err
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_FLUSH = 2'b01,
        ST_SAVED = 2'b10
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t                state_r;
    logic [3:0]            cnt_r;
    logic [STATUS_W-1:0]   ccr_r;
    logic [STATUS_W-1:0]   shadow_r;
    logic                  shadow_valid_r;
    logic                  seq_err_r;

    logic [STATUS_W-1:0]   alu_mask_s;
    logic [STATUS_W-1:0]   step1_s;
    logic [STATUS_W-1:0]   test_s;
    logic [STATUS_W-1:0]   clr_s;
    logic [STATUS_W-1:0]   cleared_s;
    logic [STATUS_W-1:0]   upd_s;
    logic                  c_s;
    logic                  taken_s;
    logic                  err_s;

    // Flags written by each ALU opcode; V is never written from the ALU path.
    function automatic logic [3:0] flag_mask(input logic [3:0] op);
        logic [3:0] m;
        case (op)
            4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b1000, 4'b1001: m = 4'b0111;
            4'b0010, 4'b0110:                                     m = 4'b0011;
            default:                                              m = 4'b0000;
        endcase
        return m;
    endfunction

    // Next-CCR composition for a normal update and the branch decision.
    always_comb begin
        alu_mask_s = flag_mask(alu_op);
        if (ex_valid && !stall) begin
            step1_s = (ccr_r & ~alu_mask_s) | (alu_status & alu_mask_s);
        end else begin
            step1_s = ccr_r;
        end
`ifdef CCR_FWD_EN
        if (state_r == ST_FLUSH) begin
            test_s = ccr_r;
        end else begin
            test_s = step1_s;
        end
`else
        test_s = ccr_r;
`endif
        taken_s = br_valid && ((br_cond == 2'b11) || test_s[br_cond]);
        if (taken_s && (br_cond != 2'b11)) begin
            clr_s = 4'b0001 << br_cond;
        end else begin
            clr_s = 4'b0000;
        end
        cleared_s = step1_s & ~clr_s;
        if (setc) begin
            c_s = 1'b1;
        end else if (clrc) begin
            c_s = 1'b0;
        end else begin
            c_s = cleared_s[2];
        end
        upd_s = {cleared_s[3], c_s, cleared_s[1:0]};
    end

    // Illegal save/restore requests for the current sequencing state.
    always_comb begin
        case (state_r)
            ST_RUN:   err_s = rti_restore;
            ST_FLUSH: err_s = int_save || rti_restore;
            ST_SAVED: err_s = int_save;
            default:  err_s = 1'b0;
        endcase
    end

    // CCR, shadow and save/restore sequencing FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_RUN;
            cnt_r          <= 4'd0;
            ccr_r          <= 4'b0000;
            shadow_r       <= 4'b0000;
            shadow_valid_r <= 1'b0;
            seq_err_r      <= 1'b0;
        end else begin
            if (err_s) begin
                seq_err_r <= 1'b1;
            end
            if (!stall) begin
                case (state_r)
                    ST_RUN: begin
                        ccr_r <= upd_s;
                        // A same-cycle rti_restore pre-empts the save.
                        if (int_save && !rti_restore) begin
                            shadow_r       <= ccr_r;
                            cnt_r          <= FLUSH_LOAD;
                            state_r        <= ST_FLUSH;
                            shadow_valid_r <= 1'b1;
                        end
                    end
                    ST_FLUSH: begin
                        if (cnt_r == 4'd0) begin
                            state_r <= ST_SAVED;
                        end else begin
                            cnt_r <= cnt_r - 4'd1;
                        end
                    end
                    ST_SAVED: begin
                        if (rti_restore) begin
                            ccr_r          <= shadow_r;
                            state_r        <= ST_RUN;
                            shadow_valid_r <= 1'b0;
                        end else begin
                            ccr_r <= upd_s;
                        end
                    end
                    default: begin
                        state_r        <= ST_RUN;
                        shadow_valid_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign br_taken     = taken_s;
    assign ccr          = ccr_r;
    assign shadow_valid = shadow_valid_r;
    assign seq_err      = seq_err_r;

endmodule
